// File: rtl/gnrl_pipe_skid.sv
// Two-entry valid/ready pipeline slice with skid buffer; registered data and ready paths.
// Optional synchronous flush port enabled by defining GNRL_PIPE_SKID_FLUSH_EN.
module gnrl_pipe_skid #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
`ifdef GNRL_PIPE_SKID_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    o_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] main_q, skid_q;
  logic          in_fire, out_fire;
  logic          load_main, main_from_skid, load_skid;
  logic          flush_int;

`ifdef GNRL_PIPE_SKID_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Handshake outputs decode the state register only, so no combinational path crosses the slice.
  assign i_rdy    = (state != TWO);
  assign o_vld    = (state != EMPTY);
  assign o_cnt    = state;
  assign o_dat    = main_q;
  assign in_fire  = i_vld & i_rdy;
  assign out_fire = o_vld & o_rdy;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: load_main = 1'b1;
          2'b10: begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          state_nxt      = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops the state and any transfer this cycle; data registers keep their contents.
    if (flush_int) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : i_dat;
      if (load_skid) skid_q <= i_dat;
    end
  end

endmodule

// File: tb/tb_gnrl_pipe_skid.sv
// Directed and queue-referenced random checks for gnrl_pipe_skid.
module tb_gnrl_pipe_skid;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rstn;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [1:0]    o_cnt;
`ifdef GNRL_PIPE_SKID_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;

  gnrl_pipe_skid #(.DW(DW)) dut (
    .clk   (clk),
    .rstn  (rstn),
`ifdef GNRL_PIPE_SKID_FLUSH_EN
    .flush (flush),
`endif
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [1:0] c, input logic [31:0] d);
    chk({tag, ".o_vld"}, {31'd0, o_vld}, {31'd0, v});
    chk({tag, ".i_rdy"}, {31'd0, i_rdy}, {31'd0, r});
    chk({tag, ".o_cnt"}, {30'd0, o_cnt}, {30'd0, c});
    chk({tag, ".o_dat"}, o_dat, d);
  endtask

  logic [31:0] q[$];
  logic [31:0] next_word;
  logic        pend;
  logic        ifire, ofire;

  initial begin
    rstn  = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'hDEAD_BEEF;
    o_rdy = 1'b0;
`ifdef GNRL_PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    chk_state("reset", 1'b0, 1'b1, 2'd0, 32'h0);

    rstn  = 1'b1;
    o_rdy = 1'b1;
    tick();
    chk_state("first", 1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF);
    i_vld = 1'b0;
    tick();
    chk_state("drain0", 1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF);

    // streaming at full rate
    i_vld = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_dat = k;
      tick();
      chk_state($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, k);
    end
    i_vld = 1'b0;
    tick();
    chk_state("stream_end", 1'b0, 1'b1, 2'd0, 32'd8);

    // o_rdy while empty has no effect
    tick();
    chk_state("idle_rdy", 1'b0, 1'b1, 2'd0, 32'd8);

    // backpressure
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'hA;
    tick();
    chk_state("bp_a", 1'b1, 1'b1, 2'd1, 32'hA);
    i_dat = 32'hB;
    tick();
    chk_state("bp_full", 1'b1, 1'b0, 2'd2, 32'hA);
    i_dat = 32'hC;
    tick();
    chk_state("bp_ignore", 1'b1, 1'b0, 2'd2, 32'hA);
    o_rdy = 1'b1;
    tick();
    chk_state("bp_popa", 1'b1, 1'b1, 2'd1, 32'hB);
    tick();
    chk_state("bp_c", 1'b1, 1'b1, 2'd1, 32'hC);
    i_vld = 1'b0;
    tick();
    chk_state("bp_end", 1'b0, 1'b1, 2'd0, 32'hC);

    // simultaneous fire in ONE
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'd5;
    tick();
    chk_state("sim_5", 1'b1, 1'b1, 2'd1, 32'd5);
    i_dat = 32'd6;
    o_rdy = 1'b1;
    tick();
    chk_state("sim_6", 1'b1, 1'b1, 2'd1, 32'd6);
    i_vld = 1'b0;
    tick();
    chk_state("sim_end", 1'b0, 1'b1, 2'd0, 32'd6);

    // asynchronous reset while full
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'h11;
    tick();
    i_dat = 32'h22;
    tick();
    chk_state("pre_rst", 1'b1, 1'b0, 2'd2, 32'h11);
    i_vld = 1'b0;
    rstn  = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 1'b1, 2'd0, 32'h0);
    tick();
    rstn  = 1'b1;
    o_rdy = 1'b1;
    tick();
    chk_state("post_rst", 1'b0, 1'b1, 2'd0, 32'h0);

`ifdef GNRL_PIPE_SKID_FLUSH_EN
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'd7;
    tick();
    i_dat = 32'd9;
    tick();
    chk_state("fl_full", 1'b1, 1'b0, 2'd2, 32'd7);
    flush = 1'b1;
    i_dat = 32'd11;
    o_rdy = 1'b1;
    tick();
    flush = 1'b0;
    i_vld = 1'b0;
    chk({"flush", ".o_vld"}, {31'd0, o_vld}, 32'd0);
    chk({"flush", ".i_rdy"}, {31'd0, i_rdy}, 32'd1);
    chk({"flush", ".o_cnt"}, {30'd0, o_cnt}, 32'd0);
    tick();
    chk({"flush_hold", ".o_cnt"}, {30'd0, o_cnt}, 32'd0);
    i_vld = 1'b1;
    i_dat = 32'd13;
    tick();
    i_vld = 1'b0;
    chk_state("flush_next", 1'b1, 1'b1, 2'd1, 32'd13);
    tick();
    chk_state("flush_end", 1'b0, 1'b1, 2'd0, 32'd13);
`endif

    // random handshakes against a reference queue
    q.delete();
    pend      = 1'b0;
    next_word = 32'h1000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend) begin
        i_vld = ($urandom_range(0, 99) < 60);
        if (i_vld) begin
          i_dat     = next_word;
          next_word = next_word + 32'd1;
        end
      end
      o_rdy = ($urandom_range(0, 99) < 50);
      chk("rnd.i_rdy", {31'd0, i_rdy}, {31'd0, (q.size() < 2)});
      chk("rnd.o_vld", {31'd0, o_vld}, {31'd0, (q.size() > 0)});
      chk("rnd.o_cnt", {30'd0, o_cnt}, 32'(q.size()));
      if (q.size() > 0) chk("rnd.o_dat", o_dat, q[0]);
      ifire = i_vld && (q.size() < 2);
      ofire = o_rdy && (q.size() > 0);
      pend  = i_vld && !ifire;
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(i_dat);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
